// File: rtl/int_controller_if.sv
// Request/acknowledge, injected-instruction and config bus between the CPU side and int_controller.
// Pure wiring: no latency of its own.
// No backpressure: the CPU paces the controller only through ACK and int_done.
//
// Signals:
//   irq[NUM_SRC]        peripheral requests (rising-edge sensitive)
//   ACK, int_done       CPU acknowledge / return-from-interrupt pulses
//   cfg_we/addr/wdata   config write port; cfg_rdata combinational read data
//   INT, INT_INSTR      interrupt request and injected instruction word
//   active_id, busy     source under service; controller not idle
//   timeout_err         sticky ACK-timeout flag
// Modports: master = CPU/peripheral side, slave = controller.
interface int_controller_if #(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0] irq;
    logic               ACK;
    logic               int_done;
    logic               cfg_we;
    logic [4:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               INT;
    logic [31:0]        INT_INSTR;
    logic [3:0]         active_id;
    logic               busy;
    logic               timeout_err;

    modport master (
        output irq, ACK, int_done, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, INT, INT_INSTR, active_id, busy, timeout_err
    );

    modport slave (
        input  irq, ACK, int_done, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, INT, INT_INSTR, active_id, busy, timeout_err
    );
endinterface

// File: rtl/int_controller.sv
// Edge-latching, masked, fixed-priority interrupt controller that injects NOOP pad + handler jump.
// Latency: irq edge -> INT in 2 cycles; ACK -> first injected word next cycle.
// Backpressure: holds INT until ACK, then blocks new service until int_done.
//
// Ports: clk, rst (synchronous, active high), ic_if (int_controller_if.slave):
//   irq/ACK/int_done/cfg_we/cfg_addr/cfg_wdata in; cfg_rdata/INT/INT_INSTR/active_id/busy/timeout_err out.
// Optional macro INT_TIMEOUT_EN: abandon a REQ after TIMEOUT cycles without ACK and set sticky timeout_err.
// Config map: 0..NUM_SRC-1 vector[26:0]; 0x10 enable mask; 0x11 pending (read, write-1-to-clear).
module int_controller #(
    parameter int NUM_SRC = 8,
    parameter int INJ_PAD = 2,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    int_controller_if.slave ic_if
);
    localparam logic [31:0] NOOP      = 32'h7800_0000;
    localparam logic [4:0]  ADDR_MASK = 5'h10;
    localparam logic [4:0]  ADDR_PEND = 5'h11;
    localparam logic [4:0]  ADDR_NSRC = 5'(NUM_SRC);
    // Internal source vectors are always 16 wide so a 4-bit id indexes them cleanly;
    // bits at or above NUM_SRC are forced to zero.
    localparam logic [15:0] SRC_MASK  = 16'((32'd1 << NUM_SRC) - 32'd1);
    localparam logic [2:0]  PAD_LAST  = 3'((INJ_PAD > 0) ? INJ_PAD - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_PAD, S_JMP, S_SERVICE} state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] irq_q;
    logic [26:0] vec_q [16];
    logic [3:0]  id_q, id_d;
    logic [2:0]  pad_q, pad_d;

    logic [15:0] irq_ext, edge_set, elig, w1c, ack_clr;
    logic [3:0]  winner;
    logic        win_vld;
    logic        ack_take;
    logic        to_hit;
    logic        unused_wdata;

    assign unused_wdata = &{1'b0, ic_if.cfg_wdata[31:27]};

    assign irq_ext  = 16'(ic_if.irq);
    assign edge_set = irq_ext & ~irq_q;
    assign elig     = pend_q & mask_q;
    assign w1c      = (ic_if.cfg_we && ic_if.cfg_addr == ADDR_PEND) ? ic_if.cfg_wdata[15:0] : 16'd0;
    assign ack_clr  = ack_take ? (16'd1 << id_q) : 16'd0;

    // A new edge overrides both W1C and the ACK clear on the same bit.
    assign pend_d = ((pend_q & ~w1c & ~ack_clr) | edge_set) & SRC_MASK;
    assign mask_d = (ic_if.cfg_we && ic_if.cfg_addr == ADDR_MASK) ?
                    (ic_if.cfg_wdata[15:0] & SRC_MASK) : mask_q;

    // Lowest index wins: scan downward so the last hit is the lowest.
    always_comb begin
        winner  = 4'd0;
        win_vld = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (elig[i]) begin
                winner  = 4'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        pad_d    = pad_q;
        ack_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    id_d    = winner;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // ACK takes precedence over a timeout in the same cycle.
                if (ic_if.ACK) begin
                    ack_take = 1'b1;
                    pad_d    = 3'd0;
                    if (INJ_PAD > 0) state_d = S_PAD;
                    else             state_d = S_JMP;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_PAD: begin
                if (pad_q == PAD_LAST) state_d = S_JMP;
                else                   pad_d   = pad_q + 3'd1;
            end
            S_JMP:     state_d = S_SERVICE;
            S_SERVICE: if (ic_if.int_done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            irq_q   <= '0;
            id_q    <= '0;
            pad_q   <= '0;
            for (int i = 0; i < 16; i++) vec_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            irq_q   <= irq_ext;
            id_q    <= id_d;
            pad_q   <= pad_d;
            if (ic_if.cfg_we && ic_if.cfg_addr < ADDR_NSRC)
                vec_q[ic_if.cfg_addr[3:0]] <= ic_if.cfg_wdata[26:0];
        end
    end

`ifdef INT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] to_q;
    logic        err_q;

    // to_q counts completed REQ cycles; the TIMEOUT-th one without ACK abandons the request.
    assign to_hit = (state_q == S_REQ) && (to_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_REQ && state_d == S_REQ) to_q <= to_q + 16'd1;
            else                                       to_q <= '0;
            if (to_hit && !ic_if.ACK) err_q <= 1'b1;
        end
    end
    assign ic_if.timeout_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign to_hit            = 1'b0;
    assign ic_if.timeout_err = 1'b0;
`endif

    assign ic_if.INT       = (state_q == S_REQ);
    assign ic_if.busy      = (state_q != S_IDLE);
    assign ic_if.active_id = id_q;
    assign ic_if.INT_INSTR = (state_q == S_JMP) ? {5'b10100, vec_q[id_q]} : NOOP;

    always_comb begin
        ic_if.cfg_rdata = 32'd0;
        if (ic_if.cfg_addr < ADDR_NSRC)      ic_if.cfg_rdata = {5'd0, vec_q[ic_if.cfg_addr[3:0]]};
        else if (ic_if.cfg_addr == ADDR_MASK) ic_if.cfg_rdata = {16'd0, mask_q};
        else if (ic_if.cfg_addr == ADDR_PEND) ic_if.cfg_rdata = {16'd0, pend_q};
    end
endmodule
